// File: rtl/dump_pkg.sv
// rtl/dump_pkg.sv - shared types and constants for the memory dump streamer
//
// Holds the dump FSM state encoding, the word/byte geometry and a byte
// selection helper used by the streamer.

package dump_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    // Byte lane idx of a word, lane 0 being the least-significant byte.
    function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] word,
                                                  input logic [1:0]        idx);
        return word[{idx, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/mem_dump_streamer_if.sv
// rtl/mem_dump_streamer_if.sv - memory read port and byte stream bundle
//
// Ports (signals):
//   mem_rd_en, mem_addr  streamer -> memory  read strobe and word address
//   mem_rdata            memory -> streamer  read data, one cycle after mem_rd_en
//   tx_valid, tx_data,
//   tx_last              streamer -> sink    byte stream, final byte marked
//   tx_ready             sink -> streamer    byte accepted
// Modports: master (streamer side), slave (memory + sink side).

interface mem_dump_streamer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              tx_last;

    modport master (
        output mem_rd_en, mem_addr, tx_valid, tx_data, tx_last,
        input  mem_rdata, tx_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, tx_valid, tx_data, tx_last,
        output mem_rdata, tx_ready
    );

endinterface

// File: rtl/mem_dump_streamer.sv
// rtl/mem_dump_streamer.sv - reads a word range from memory and streams it out LSB byte first
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               command strobe, only honoured in IDLE
//   start_addr          first word address of the dump
//   word_count          number of words, 0..2^ADDR_W
//   busy                high in READ, CAPTURE and SEND
//   done                one-cycle completion pulse
//   bus (master)        memory read port and byte stream

module mem_dump_streamer
    import dump_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    mem_dump_streamer_if.master bus
);

    localparam logic [1:0]      LAST_IDX = 2'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] buf_q,   buf_d;
    logic [1:0]        idx_q,   idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        addr_d  = start_addr;
                        count_d = word_count;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                buf_d   = bus.mem_rdata;
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        // Address wraps naturally at 2^ADDR_W.
                        count_d = count_q - CNT_ONE;
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = (count_q == CNT_ONE) ? ST_DONE : ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so tx_valid never
    // depends on tx_ready and everything reads 0 outside the active states.
    always_comb begin
        busy          = (state_q == ST_READ) || (state_q == ST_CAPTURE) || (state_q == ST_SEND);
        done          = (state_q == ST_DONE);
        bus.mem_rd_en = (state_q == ST_READ);
        bus.mem_addr  = (state_q == ST_READ) ? addr_q : '0;
        bus.tx_valid  = (state_q == ST_SEND);
        bus.tx_data   = (state_q == ST_SEND) ? byte_of(buf_q, idx_q) : '0;
        bus.tx_last   = (state_q == ST_SEND) && (idx_q == LAST_IDX) && (count_q == CNT_ONE);
    end

endmodule

// File: doc/mem_dump_streamer.md
# mem_dump_streamer

Debug read-back engine for the single-cycle core. On a `start` command it reads a contiguous range of words from a synchronous-read memory port (data memory or instruction memory) and streams them out byte by byte over a valid/ready interface, least-significant byte first. It replaces hierarchical `$display` peeking of memory state with a hardware path that a host-side receiver can consume.

## Interface

**Parameters**
- `ADDR_W`, 8: word-address width; the memory holds 2^ADDR_W words.
- `DATA_W`, 32: memory word width; fixed at 32 (4 bytes per word).

**Ports**
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first word address; sampled with `start`.
- `word_count`  in  ADDR_W+1  number of words to dump, 0..2^ADDR_W; sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance until the final byte handshake.
- `done`  out  1  one-cycle pulse after the final byte handshake, or after a zero-length command.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  word address of the read.
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd_en`.
- `tx_valid`  out  1  byte available.
- `tx_ready`  in  1  consumer accepts the byte.
- `tx_data`  out  8  byte value.
- `tx_last`  out  1  marks the final byte of the dump.

## Operation

- **States:** IDLE, READ, CAPTURE, SEND, DONE.
- **IDLE:**
  - `start`=1 with `word_count`≠0: latch the address and count, go to READ.
  - `start`=1 with `word_count`=0: go to DONE. No reads are issued.
- **READ:** `mem_rd_en`=1 and `mem_addr`=current address for one cycle. Next state CAPTURE.
- **CAPTURE:** register `mem_rdata` into the word buffer. Clear the byte index. Next state SEND.
- **SEND:**
  - Drive `tx_valid`=1 and `tx_data`=buffer[8*idx+7 : 8*idx].
  - On each handshake (`tx_valid && tx_ready`), increment idx.
  - After the handshake with idx=3:
    - Decrement the remaining count and increment the address modulo 2^ADDR_W.
    - If count is now 0, go to DONE. Otherwise go to READ.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `tx_last` = SEND && idx==3 && remaining==1.
- `start` in any state other than IDLE is ignored, including the DONE cycle.
- The address wraps: with `start_addr`=2^ADDR_W−1, the next address is 0.
- `word_count`=2^ADDR_W dumps the full memory once. The count register is ADDR_W+1 bits.

## Timing

- **Reset:** every output is 0, state is IDLE, internal registers are cleared.
- **Reset mid-operation:** outputs read 0 on the cycle after `reset` is sampled. No further bytes are produced.
- **Command to first read:** `start` sampled at cycle 0 gives READ (`mem_rd_en`) in cycle 1, CAPTURE in cycle 2, and first `tx_valid` in cycle 3.
- **Per-word cost:** 2 + 4 cycles under continuous `tx_ready`.
- **Last byte to done:** the final handshake in cycle k gives `done` in cycle k+1 and IDLE in cycle k+2.
- **`busy`:** high in READ, CAPTURE and SEND; low in IDLE and DONE.
- **Backpressure rule:** while `tx_valid && !tx_ready`, `tx_data` and `tx_last` hold stable and `tx_valid` stays high.
- `tx_valid` never depends combinationally on `tx_ready`.
- `mem_rd_en` is asserted only in READ, so there is exactly one read per word.

## Structure

- **Shared package `dump_pkg`:** holds the state enum `dump_state_t`, `BYTES_PER_WORD`=4, and `BYTE_W`=8.
- **Sub-module:** none. A single module with one FSM, one address counter, one count register, one word buffer and a 2-bit byte index.

## Test plan

- **Basic dump:**
  - Setup: memory[0..4]=5,10,20,30,40; `start_addr`=1, `word_count`=2, `tx_ready`=1, `start` at cycle 0.
  - Expect bytes 0A 00 00 00 in cycles 3-6 and 14 00 00 00 in cycles 9-12.
  - Expect `tx_last` only in cycle 12, `done` in cycle 13, and `mem_rd_en` in cycles 1 and 7 only.
- **Backpressure:**
  - Setup: same command; drop `tx_ready` for 3 cycles while byte 1 of word 0 is presented.
  - Expect `tx_data`=00 and `tx_valid`=1 held for those cycles, the byte sequence unchanged, and `done` delayed by 3 cycles.
- **Wrap:**
  - Setup: `ADDR_W`=8; memory[255]=0xDEADBEEF, memory[0]=5; `start_addr`=255, `word_count`=2.
  - Expect `mem_addr`=255 then 0, and bytes EF BE AD DE 05 00 00 00.
- **Zero count:**
  - Setup: `word_count`=0 with `start`.
  - Expect no `mem_rd_en`, no `tx_valid`, `done`=1 in cycle 1, and `busy` never high.
- **Ignored start:**
  - Setup: pulse `start` with `start_addr`=3 during SEND of a 1-word dump at address 0.
  - Expect exactly 4 bytes from address 0 and no second dump.
- **Reset mid-send:**
  - Setup: assert `reset` after byte 2 of word 0.
  - Expect all outputs 0 on the next cycle.
  - Expect a new 1-word dump of address 4 afterwards to yield 28 00 00 00 with correct `tx_last`/`done`.
